// File: rtl/ethernet_header_rx.sv
`default_nettype none
// ============================================================================
// Module      : ethernet_header_rx
// Description : Parses the 14-byte Ethernet MAC header from a post-SFD frame
//               stream delivered as N-bit chunks. Frames addressed to MY_MAC
//               or to broadcast, with ethertype IPv4 (0x0800) or ARP (0x0806),
//               have their payload chunks forwarded with one cycle of latency.
//               All other frames, and frames cut short inside the header, are
//               dropped and signalled with a one-cycle frame_drop pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N              chunk width in bits (1, 2, 4 or 8)
//   MY_MAC         station MAC accepted as destination
// Ports
//   clk            system clock
//   rst            asynchronous active-high reset
//   axiiv, axiid   input chunk valid / data (valid high for a whole frame)
//   axiov, axiod   payload chunk valid / data
//   ethertype_out  0 = IPv4, 1 = ARP (held while axiov is high)
//   dst_mac_out    destination MAC of the last accepted frame
//   src_mac_out    source MAC of the last accepted frame
//   frame_drop     one-cycle pulse on a rejected or truncated frame
// Build option
//   ETHERNET_HEADER_RX_PROMISC_EN  when defined, any destination MAC is
//                                  accepted; the ethertype filter still applies
// ============================================================================
module ethernet_header_rx #(
  parameter int          N      = 2,
  parameter logic [47:0] MY_MAC = 48'h02_00_00_00_00_01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         axiiv,
  input  logic [N-1:0] axiid,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic         ethertype_out,
  output logic [47:0]  dst_mac_out,
  output logic [47:0]  src_mac_out,
  output logic         frame_drop
);

  localparam int                 c_hdr   = 112 / N;
  localparam int                 c_cnt_w = $clog2(c_hdr) + 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(c_hdr - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_DROP    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [111:0]         r_hdr;
  logic [111:0]         w_hdr_nxt;
  logic [111:0]         w_hdr_ins;
  logic [7:0]           w_pos_lin;
  logic [6:0]           w_idx;
  logic                 r_in_frame;
  logic                 r_axiov;
  logic                 w_axiov_nxt;
  logic [N-1:0]         r_axiod;
  logic [N-1:0]         w_axiod_nxt;
  logic                 r_frame_drop;
  logic                 w_drop_nxt;
  logic                 w_load_hdr;
  logic [47:0]          r_dst_mac;
  logic [47:0]          r_src_mac;
  logic                 r_ethertype;
  logic                 w_type_ip;
  logic                 w_type_arp;
  logic                 w_dst_ok;
  logic                 w_accept;

  // Header image with the current chunk dropped into place. Bytes run MSB
  // first through the 112-bit register (byte 0 at [111:104]) while chunks
  // within a byte run LSB first, so the landing bit is
  //   104 - 8*byte + bit_in_byte, with byte/bit taken from cnt*N.
  always_comb begin
    w_pos_lin = 8'(r_cnt) * 8'(N);
    w_idx     = 7'(8'd104 - {w_pos_lin[7:3], 3'b000} + {5'b00000, w_pos_lin[2:0]});
    w_hdr_ins = r_hdr;
    w_hdr_ins[w_idx +: N] = axiid;
  end

  // Filter decision, evaluated on the image that already includes the final
  // header chunk so the verdict is ready on the cycle that chunk arrives.
  always_comb begin
    w_type_ip  = (w_hdr_ins[15:0] == 16'h0800);
    w_type_arp = (w_hdr_ins[15:0] == 16'h0806);
`ifdef ETHERNET_HEADER_RX_PROMISC_EN
    w_dst_ok   = 1'b1;
`else
    w_dst_ok   = (w_hdr_ins[111:64] == MY_MAC) ||
                 (w_hdr_ins[111:64] == 48'hFFFF_FFFF_FFFF);
`endif
    w_accept   = w_dst_ok && (w_type_ip || w_type_arp);
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hdr_nxt   = r_hdr;
    w_axiov_nxt = 1'b0;
    w_axiod_nxt = '0;
    w_drop_nxt  = 1'b0;
    w_load_hdr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // r_in_frame blocks the tail of a frame interrupted by reset.
        if (axiiv && !r_in_frame) begin
          w_hdr_nxt   = w_hdr_ins;
          w_cnt_nxt   = c_cnt_w'(1);
          w_state_nxt = S_HEADER;
        end
      end
      S_HEADER: begin
        if (!axiiv) begin
          w_drop_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_hdr_nxt = w_hdr_ins;
          if (r_cnt == c_last) begin
            w_cnt_nxt = '0;
            if (w_accept) begin
              w_load_hdr  = 1'b1;
              w_state_nxt = S_PAYLOAD;
            end else begin
              w_drop_nxt  = 1'b1;
              w_state_nxt = S_DROP;
            end
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
          end
        end
      end
      S_PAYLOAD: begin
        if (axiiv) begin
          w_axiov_nxt = 1'b1;
          w_axiod_nxt = axiid;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (!axiiv) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_hdr        <= '0;
      r_axiov      <= 1'b0;
      r_axiod      <= '0;
      r_frame_drop <= 1'b0;
      r_dst_mac    <= '0;
      r_src_mac    <= '0;
      r_ethertype  <= 1'b0;
      // Assume a frame may be in flight; only an idle input cycle clears it.
      r_in_frame   <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hdr        <= w_hdr_nxt;
      r_axiov      <= w_axiov_nxt;
      r_axiod      <= w_axiod_nxt;
      r_frame_drop <= w_drop_nxt;
      r_in_frame   <= axiiv;
      if (w_load_hdr) begin
        r_dst_mac   <= w_hdr_ins[111:64];
        r_src_mac   <= w_hdr_ins[63:16];
        r_ethertype <= w_type_arp;
      end
    end
  end

  assign axiov         = r_axiov;
  assign axiod         = r_axiod;
  assign ethertype_out = r_ethertype;
  assign dst_mac_out   = r_dst_mac;
  assign src_mac_out   = r_src_mac;
  assign frame_drop    = r_frame_drop;

endmodule
`default_nettype wire

// File: tb/tb_ethernet_header_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ethernet_header_rx
// Description : Directed self-checking bench for ethernet_header_rx (N = 2).
//               Honours ETHERNET_HEADER_RX_PROMISC_EN for the wrong-dst case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ethernet_header_rx;

  localparam int          N      = 2;
  localparam logic [47:0] c_my   = 48'h0200_0000_0001;
  localparam logic [47:0] c_bc   = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] c_srca = 48'hAABB_CCDD_EEFF;
  localparam logic [47:0] c_srcb = 48'h1122_3344_5566;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         axiiv = 1'b0;
  logic [N-1:0] axiid = '0;
  logic         axiov;
  logic [N-1:0] axiod;
  logic         ethertype_out;
  logic [47:0]  dst_mac_out;
  logic [47:0]  src_mac_out;
  logic         frame_drop;

  ethernet_header_rx #(.N(N), .MY_MAC(c_my)) dut (
    .clk           (clk),
    .rst           (rst),
    .axiiv         (axiiv),
    .axiid         (axiid),
    .axiov         (axiov),
    .axiod         (axiod),
    .ethertype_out (ethertype_out),
    .dst_mac_out   (dst_mac_out),
    .src_mac_out   (src_mac_out),
    .frame_drop    (frame_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int g_abs;
  int first_abs;
  int drop_cnt;
  int drop_abs;
  logic [N-1:0] q_out[$];
  logic [N-1:0] q_ch[$];
  logic [N-1:0] q_exp[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    q_out.delete();
    g_abs     = 0;
    first_abs = -1;
    drop_cnt  = 0;
    drop_abs  = -1;
  endtask

  // Sample outputs produced by the previous rising edge (index g_abs), then
  // drive the next input chunk, which is taken at edge g_abs+1.
  task automatic step(input logic v, input logic [N-1:0] d);
    @(negedge clk);
    if (axiov) begin
      if (first_abs < 0) first_abs = g_abs;
      q_out.push_back(axiod);
    end
    if (frame_drop) begin
      drop_cnt++;
      drop_abs = g_abs;
    end
    axiiv = v;
    axiid = d;
    g_abs++;
  endtask

  // seed < 0 selects the fixed IPv4 payload 45 00 00 1C.
  task automatic build(input logic [47:0] dst, input logic [47:0] src,
                       input logic [15:0] et, input int npay, input int seed);
    logic [7:0]  b;
    logic [31:0] ip;
    ip = 32'h4500_001C;
    q_ch.delete();
    q_exp.delete();
    for (int i = 0; i < 14 + npay; i++) begin
      if (i < 6)       b = dst[47-8*i -: 8];
      else if (i < 12) b = src[47-8*(i-6) -: 8];
      else if (i < 14) b = et[15-8*(i-12) -: 8];
      else if (seed < 0) b = ip[31-8*(i-14) -: 8];
      else             b = 8'(seed + 29 * (i - 14));
      for (int c = 0; c < 8 / N; c++) begin
        q_ch.push_back(b[c*N +: N]);
        if (i >= 14) q_exp.push_back(b[c*N +: N]);
      end
    end
  endtask

  task automatic send(input int nch, input int nidle);
    for (int i = 0; i < nch; i++) step(1'b1, q_ch[i]);
    repeat (nidle) step(1'b0, '0);
  endtask

  function automatic int mism();
    int m = 0;
    if (q_out.size() != q_exp.size()) return 1000;
    foreach (q_exp[i]) if (q_out[i] !== q_exp[i]) m++;
    return m;
  endfunction

  initial begin
    // ---------------- reset state ----------------
    #12;
    chk("rst_axiov", axiov, 0);
    chk("rst_axiod", axiod, 0);
    chk("rst_drop", frame_drop, 0);
    chk("rst_hdr", {ethertype_out, dst_mac_out, src_mac_out}, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    repeat (2) step(1'b0, '0);

    // ---------------- unicast IPv4 ----------------
    clear_log();
    build(c_my, c_srca, 16'h0800, 4, -1);
    send(q_ch.size(), 3);
    chk("uc_first_abs", first_abs, 57);
    chk("uc_count", q_out.size(), 16);
    chk("uc_first_d", q_out.size() > 0 ? q_out[0] : 2'bxx, 2'b01);
    chk("uc_data", mism(), 0);
    chk("uc_type", ethertype_out, 0);
    chk("uc_src", src_mac_out, c_srca);
    chk("uc_dst", dst_mac_out, c_my);
    chk("uc_drop", drop_cnt, 0);

    // ---------------- broadcast ARP ----------------
    clear_log();
    build(c_bc, c_srcb, 16'h0806, 28, 7);
    send(q_ch.size(), 3);
    chk("arp_type", ethertype_out, 1);
    chk("arp_count", q_out.size(), 112);
    chk("arp_data", mism(), 0);
    chk("arp_dst", dst_mac_out, c_bc);
    chk("arp_drop", drop_cnt, 0);

    // ---------------- wrong destination ----------------
    clear_log();
    build(48'h0200_0000_0002, c_srca, 16'h0800, 4, -1);
    send(q_ch.size(), 3);
`ifdef ETHERNET_HEADER_RX_PROMISC_EN
    chk("wd_count", q_out.size(), 16);
    chk("wd_data", mism(), 0);
    chk("wd_drop", drop_cnt, 0);
    chk("wd_dst", dst_mac_out, 48'h0200_0000_0002);
`else
    chk("wd_count", q_out.size(), 0);
    chk("wd_drop", drop_cnt, 1);
    chk("wd_drop_at", drop_abs, 56);
    chk("wd_src_keep", src_mac_out, c_srcb);
    chk("wd_type_keep", ethertype_out, 1);
`endif

    // ---------------- bad ethertype ----------------
    clear_log();
    build(c_my, c_srcb, 16'h86DD, 4, 3);
    send(q_ch.size(), 3);
    chk("et_count", q_out.size(), 0);
    chk("et_drop", drop_cnt, 1);
    chk("et_drop_at", drop_abs, 56);

    // ---------------- runt then valid frame after one idle ----------------
    clear_log();
    build(c_my, c_srcb, 16'h0806, 4, 1);
    send(20, 1);
    build(c_my, c_srca, 16'h0800, 4, -1);
    send(q_ch.size(), 3);
    chk("runt_drop", drop_cnt, 1);
    chk("runt_drop_at", drop_abs, 21);
    chk("runt_next_first", first_abs, 78);
    chk("runt_next_data", mism(), 0);
    chk("runt_next_type", ethertype_out, 0);

    // ---------------- reset at payload chunk 5 ----------------
    clear_log();
    build(c_my, c_srcb, 16'h0806, 4, 9);
    for (int i = 1; i <= 61; i++) step(1'b1, q_ch[i-1]);
    chk("mr_pre_axiov", axiov, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_async_axiov", axiov, 0);
    chk("mr_async_hdr", {ethertype_out, dst_mac_out, src_mac_out}, 0);
    clear_log();
    step(1'b1, q_ch[61]);
    rst = 1'b0;
    for (int i = 63; i <= q_ch.size(); i++) step(1'b1, q_ch[i-1]);
    repeat (3) step(1'b0, '0);
    chk("mr_tail_silent", q_out.size(), 0);
    chk("mr_tail_drop", drop_cnt, 0);
    clear_log();
    build(c_my, c_srca, 16'h0800, 4, -1);
    send(q_ch.size(), 3);
    chk("mr_next_first", first_abs, 57);
    chk("mr_next_data", mism(), 0);
    chk("mr_next_src", src_mac_out, c_srca);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ethernet_header_rx.md
Name: ethernet_header_rx

Overview:
- Sits directly upstream of the network-layer receiver.
- Consumes the post-SFD Ethernet frame stream as N-bit chunks and parses the 14-byte MAC header: destination MAC, source MAC and ethertype.
- Filters frames on destination MAC and ethertype, then forwards only the payload chunks, with an ethertype select bit (0 = IPv4, 1 = ARP) that drives the network-layer demux.

Parameters:
- N, 2, chunk width in bits; legal values 1, 2, 4, 8.
- MY_MAC, 48'h02_00_00_00_00_01, station MAC address accepted as destination.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- axiiv  input  1  input chunk valid; high for the whole frame, low between frames.
- axiid  input  N  input chunk.
- axiov  output  1  payload chunk valid.
- axiod  output  N  payload chunk.
- ethertype_out  output  1  0 = IPv4 (0x0800), 1 = ARP (0x0806); stable while axiov is high.
- dst_mac_out  output  48  destination MAC of the last accepted frame.
- src_mac_out  output  48  source MAC of the last accepted frame.
- frame_drop  output  1  one-cycle pulse when a frame is rejected or truncated.

Behaviour:
- Reset (async, rst=1): state IDLE, chunk counter 0; all outputs 0.
- Bit order:
  - Bytes arrive in network order.
  - Within a byte, the first chunk is bits [N-1:0] and the last is bits [7:8-N].
  - Byte 0 of the frame lands in dst_mac[47:40]; byte 5 in dst_mac[7:0]; bytes 6-11 in src_mac; byte 12 in ethertype[15:8]; byte 13 in ethertype[7:0].
- Header length: HDR = 112/N chunks; counter width is clog2(HDR)+1.
- State IDLE:
  - First cycle with axiiv=1: capture the chunk, counter=1, go to HEADER.
- State HEADER:
  - Each cycle with axiiv=1: shift the chunk into the 112-bit header register and increment the counter.
  - On the cycle the HDR-th chunk is accepted, evaluate the assembled header combinationally with that chunk.
  - Accept when dst == MY_MAC or dst == 48'hFFFF_FFFF_FFFF, AND ethertype is 0x0800 or 0x0806.
  - Accept: register dst_mac_out, src_mac_out and ethertype_out (1 iff 0x0806); go to PAYLOAD.
  - Reject: pulse frame_drop next cycle; go to DROP; header outputs keep their previous values.
  - axiiv=0 before the HDR-th chunk (runt frame): pulse frame_drop, go to IDLE, no outputs change.
- State PAYLOAD:
  - axiov and axiod are registered copies of axiiv and axiid, giving exactly 1 cycle latency.
  - The first payload chunk is the one accepted the cycle after the HDR-th chunk; no header chunk is ever forwarded.
  - When axiiv=0: axiov=0 on the next edge; go to IDLE.
- State DROP: axiov held 0; wait for axiiv=0, then go to IDLE.
- Back-to-back frames:
  - Frames are separated by at least one axiiv=0 cycle. IDLE is entered on that cycle, so a frame starting on the following cycle is parsed normally.
- FCS: passes through as payload; stripping and checking are done downstream.
- Reset mid-frame: immediate return to IDLE with outputs 0. The remainder of the interrupted frame is ignored until axiiv drops, via an internal "in_frame" flag that is cleared only on axiiv=0.
- No back-pressure: the block never stalls input.

Optional Feature:
- Macro: ETHERNET_HEADER_RX_PROMISC_EN.
- Defined: the destination-MAC check is skipped; any dst is accepted, and the ethertype filter still applies.
- Undefined: only MY_MAC or broadcast is accepted.

Test Plan:
- Unicast IPv4, N=2: dst=02:00:00:00:00:01, src=AA:BB:CC:DD:EE:FF, type 0x0800, 4 payload bytes 45 00 00 1C.
  - Expected: axiov is high for 16 cycles starting 1 cycle after chunk 57 is accepted.
  - Expected: first axiod=2'b01 (low dibit of 0x45), ethertype_out=0, src_mac_out=48'hAABBCCDDEEFF.
- Broadcast ARP: dst=FF:FF:FF:FF:FF:FF, type 0x0806, 28 payload bytes.
  - Expected: ethertype_out=1, 112 payload chunks forwarded, frame_drop stays 0.
- Wrong dst 02:00:00:00:00:02 with macro undefined.
  - Expected: axiov never asserts; frame_drop pulses once, 1 cycle after chunk 56; header outputs unchanged.
  - Rerun with ETHERNET_HEADER_RX_PROMISC_EN defined: frame is forwarded.
- Ethertype 0x86DD addressed to MY_MAC.
  - Expected: dropped, one frame_drop pulse.
- Runt frame: axiiv drops after 20 chunks.
  - Expected: frame_drop pulse, state returns to IDLE.
  - A valid frame starting 1 idle cycle later is forwarded correctly.
- Assert rst for 1 cycle at payload chunk 5.
  - Expected: axiov goes to 0 asynchronously; no further output until the next frame after axiiv drops, which parses normally.
